// File: rtl/bht_update_sched.sv
// Branch history table write-port scheduler.
//
// Sweeps the BHT clear one entry per cycle after reset and on flush. Queues
// resolved-branch update records in a small in-order FIFO. Commits one record
// per cycle to the BHT write port. BHT lookups are gated off while a sweep runs.
//
// Optional feature macro: BHT_SCHED_STATS_EN. When defined, it adds commit and
// drop counters. When undefined, o_commit_cnt and o_drop_cnt are tied to zero.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_flush            request a full-table clear
//   i_upd_*            update record input (valid/ready handshake)
//   o_wr_*             BHT write port (strobe, clear/alloc qualifiers, data)
//   o_lookup_en        BHT may serve predictions
//   o_busy             sweep in progress or FIFO not empty
//   o_commit_cnt       committed non-clear writes (stats build only)
//   o_drop_cnt         records discarded by flush (stats build only)

`ifndef N
`define N 32
`endif

module bht_update_sched #(
  parameter int unsigned INDEX_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_upd_valid,
  output logic               o_upd_ready,
  input  logic [INDEX_W-1:0] i_upd_index,
  input  logic [`N-1:0]      i_upd_branch_pc,
  input  logic [`N-1:0]      i_upd_target_pc,
  input  logic               i_upd_taken,
  input  logic               i_upd_hit,
  output logic               o_wr_en,
  output logic               o_wr_clear,
  output logic               o_wr_alloc,
  output logic [INDEX_W-1:0] o_wr_index,
  output logic [`N-1:0]      o_wr_branch_pc,
  output logic [`N-1:0]      o_wr_target_pc,
  output logic               o_wr_taken,
  output logic               o_lookup_en,
  output logic               o_busy,
  output logic [31:0]        o_commit_cnt,
  output logic [31:0]        o_drop_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic {StSweep, StRun} state_e;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [`N-1:0]      branch_pc;
    logic [`N-1:0]      target_pc;
    logic               taken;
    logic               hit;
  } rec_t;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  rec_t               mem_q [FIFO_DEPTH];
  rec_t               head;
  rec_t               in_rec;

  logic run, push, pop, flush_run;

  assign run       = (state_q == StRun);
  assign head      = mem_q[rd_ptr_q];
  assign push      = i_upd_valid && o_upd_ready;
  // Head is committed on the same edge it is presented; queue drains every RUN cycle.
  assign pop       = run && (count_q != '0);
  assign flush_run = run && i_flush;

  assign in_rec = '{index:     i_upd_index,
                    branch_pc: i_upd_branch_pc,
                    target_pc: i_upd_target_pc,
                    taken:     i_upd_taken,
                    hit:       i_upd_hit};

  // Sequencer next state
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    unique case (state_q)
      StSweep: begin
        if (i_flush) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == '1) begin
          sweep_idx_d = '0;
          state_d     = StRun;
        end else begin
          sweep_idx_d = sweep_idx_q + INDEX_W'(1);
        end
      end
      StRun: begin
        if (i_flush) begin
          sweep_idx_d = '0;
          state_d     = StSweep;
        end
      end
      default: begin
        state_d     = StSweep;
        sweep_idx_d = '0;
      end
    endcase
  end

  // FIFO pointer/count next state; a flush discards everything including this cycle's push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_run) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StSweep;
      sweep_idx_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Record storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_rec;
  end

  // Outputs
  always_comb begin
    o_upd_ready    = 1'b0;
    o_wr_en        = 1'b0;
    o_wr_clear     = 1'b0;
    o_wr_alloc     = 1'b0;
    o_wr_index     = '0;
    o_wr_branch_pc = '0;
    o_wr_target_pc = '0;
    o_wr_taken     = 1'b0;
    o_lookup_en    = 1'b0;
    o_busy         = 1'b1;
    unique case (state_q)
      StSweep: begin
        o_wr_en    = 1'b1;
        o_wr_clear = 1'b1;
        o_wr_index = sweep_idx_q;
      end
      StRun: begin
        o_lookup_en = 1'b1;
        o_upd_ready = (count_q < DepthCnt);
        o_busy      = (count_q != '0);
        if (count_q != '0) begin
          o_wr_en        = 1'b1;
          o_wr_alloc     = ~head.hit;
          o_wr_index     = head.index;
          o_wr_branch_pc = head.branch_pc;
          o_wr_target_pc = head.target_pc;
          o_wr_taken     = head.taken;
        end
      end
      default: ;
    endcase
  end

`ifdef BHT_SCHED_STATS_EN
  logic [31:0]     commit_cnt_q, drop_cnt_q;
  logic [CntW-1:0] drop_n;

  // Records left in the queue after this edge's pop and push are the ones a flush drops.
  always_comb begin
    drop_n = count_q;
    if (pop)  drop_n = drop_n - CntW'(1);
    if (push) drop_n = drop_n + CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (pop)       commit_cnt_q <= commit_cnt_q + 32'd1;
      if (flush_run) drop_cnt_q   <= drop_cnt_q + 32'(drop_n);
    end
  end

  assign o_commit_cnt = commit_cnt_q;
  assign o_drop_cnt   = drop_cnt_q;
`else
  assign o_commit_cnt = 32'd0;
  assign o_drop_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed self-checking bench for bht_update_sched (INDEX_W=8, FIFO_DEPTH=4).
module tb_bht_update_sched;

  logic        clk, rst, i_flush, i_upd_valid, o_upd_ready;
  logic [7:0]  i_upd_index, o_wr_index;
  logic [31:0] i_upd_branch_pc, i_upd_target_pc, o_wr_branch_pc, o_wr_target_pc;
  logic        i_upd_taken, i_upd_hit;
  logic        o_wr_en, o_wr_clear, o_wr_alloc, o_wr_taken, o_lookup_en, o_busy;
  logic [31:0] o_commit_cnt, o_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bht_update_sched #(.INDEX_W(8), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (i_flush),
    .i_upd_valid    (i_upd_valid),
    .o_upd_ready    (o_upd_ready),
    .i_upd_index    (i_upd_index),
    .i_upd_branch_pc(i_upd_branch_pc),
    .i_upd_target_pc(i_upd_target_pc),
    .i_upd_taken    (i_upd_taken),
    .i_upd_hit      (i_upd_hit),
    .o_wr_en        (o_wr_en),
    .o_wr_clear     (o_wr_clear),
    .o_wr_alloc     (o_wr_alloc),
    .o_wr_index     (o_wr_index),
    .o_wr_branch_pc (o_wr_branch_pc),
    .o_wr_target_pc (o_wr_target_pc),
    .o_wr_taken     (o_wr_taken),
    .o_lookup_en    (o_lookup_en),
    .o_busy         (o_busy),
    .o_commit_cnt   (o_commit_cnt),
    .o_drop_cnt     (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Observed status vector: {wr_en, wr_clear, wr_alloc, upd_ready, lookup_en, busy}
  function automatic logic [5:0] status();
    return {o_wr_en, o_wr_clear, o_wr_alloc, o_upd_ready, o_lookup_en, o_busy};
  endfunction

  task automatic drive_rec(input logic [7:0] idx, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic hit);
    i_upd_valid     = 1'b1;
    i_upd_index     = idx;
    i_upd_branch_pc = pc;
    i_upd_target_pc = tgt;
    i_upd_taken     = tk;
    i_upd_hit       = hit;
  endtask

  task automatic idle_inputs();
    i_upd_valid     = 1'b0;
    i_upd_index     = '0;
    i_upd_branch_pc = '0;
    i_upd_target_pc = '0;
    i_upd_taken     = 1'b0;
    i_upd_hit       = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    n_checks++;
    if (status() !== 6'b110001 || o_wr_index !== 8'h00 || o_wr_branch_pc !== 32'h0 ||
        o_wr_target_pc !== 32'h0 || o_wr_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: status=%b idx=%h pc=%h tgt=%h tk=%b, required status=110001 rest 0",
               name, status(), o_wr_index, o_wr_branch_pc, o_wr_target_pc, o_wr_taken);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    i_flush = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (status() !== 6'b110001 || o_wr_index !== i[7:0]) begin
        n_fail++;
        $display("FAIL sweep_%0d: status=%b idx=%h, required status=110001 idx=%h",
                 i, status(), o_wr_index, i[7:0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (status() !== 6'b000110) begin
      n_fail++;
      $display("FAIL first_run: status=%b, required 000110", status());
    end
  endtask

  task automatic test_single_alloc();
    drive_rec(8'h10, 32'h1010, 32'h2000, 1'b1, 1'b0);
    n_checks++;
    if (o_upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alloc_ready: ready=%b, required 1", o_upd_ready);
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if ({status(), o_wr_index, o_wr_branch_pc, o_wr_target_pc, o_wr_taken} !==
        {6'b101111, 8'h10, 32'h1010, 32'h2000, 1'b1}) begin
      n_fail++;
      $display("FAIL alloc_write: status=%b idx=%h pc=%h tgt=%h tk=%b, required 101111 10 1010 2000 1",
               status(), o_wr_index, o_wr_branch_pc, o_wr_target_pc, o_wr_taken);
    end
    @(negedge clk);
    n_checks++;
    if ({status(), o_wr_index, o_wr_branch_pc, o_wr_target_pc} !== {6'b000110, 8'h0, 64'h0}) begin
      n_fail++;
      $display("FAIL alloc_idle: status=%b idx=%h pc=%h tgt=%h, required 000110 0 0 0",
               status(), o_wr_index, o_wr_branch_pc, o_wr_target_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] idx [5] = '{8'h20, 8'h20, 8'h21, 8'hff, 8'h00};
    logic       hit [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        drive_rec(idx[k], 32'h4000 + 32'(k), 32'h8000 + 32'(k * 16), k[0], hit[k]);
        n_checks++;
        if (o_upd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_%0d: ready=%b, required 1", k, o_upd_ready);
        end
      end else begin
        idle_inputs();
      end
      if (k > 0) begin
        n_checks++;
        if ({o_wr_en, o_wr_clear, o_wr_alloc, o_wr_index, o_wr_branch_pc, o_wr_target_pc,
             o_wr_taken} !== {2'b10, ~hit[k-1], idx[k-1], 32'h4000 + 32'(k - 1),
                              32'h8000 + 32'((k - 1) * 16), 1'(k - 1)}) begin
          n_fail++;
          $display("FAIL b2b_commit_%0d: en=%b clr=%b al=%b idx=%h pc=%h tgt=%h, required idx=%h pc=%h",
                   k - 1, o_wr_en, o_wr_clear, o_wr_alloc, o_wr_index, o_wr_branch_pc,
                   o_wr_target_pc, idx[k-1], 32'h4000 + 32'(k - 1));
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (status() !== 6'b000110) begin
      n_fail++;
      $display("FAIL b2b_drained: status=%b, required 000110", status());
    end
  endtask

  // Queue drains every cycle, so continuous pushes never fill it and ready stays high.
  task automatic test_ready_hold();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive_rec(8'h80 + 8'(k), 32'hc000, 32'hd000, 1'b0, 1'b1);
      else       idle_inputs();
      n_checks++;
      if (o_upd_ready !== 1'b1 || (k > 0 && (o_wr_en !== 1'b1 || o_wr_index !== 8'h80 + 8'(k - 1)))) begin
        n_fail++;
        $display("FAIL hold_%0d: ready=%b en=%b idx=%h, required ready=1 idx=%h",
                 k, o_upd_ready, o_wr_en, o_wr_index, 8'h80 + 8'(k - 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    drive_rec(8'h33, 32'h3333, 32'h3000, 1'b1, 1'b1);
    @(negedge clk);
    // Record A is presented; B is offered alongside the flush and must be dropped.
    drive_rec(8'h44, 32'h4444, 32'h4000, 1'b0, 1'b0);
    i_flush = 1'b1;
    n_checks++;
    if ({o_wr_en, o_wr_clear, o_wr_index, o_upd_ready} !== {2'b10, 8'h33, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_commit: en=%b clr=%b idx=%h rdy=%b, required 1 0 33 1",
               o_wr_en, o_wr_clear, o_wr_index, o_upd_ready);
    end
    @(negedge clk);
    i_flush = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (status() !== 6'b110001 || o_wr_index !== i[7:0]) begin
        n_fail++;
        $display("FAIL flush_sweep_%0d: status=%b idx=%h, required 110001 idx=%h",
                 i, status(), o_wr_index, i[7:0]);
      end
      if (i < 2) @(negedge clk);
    end
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    n_checks++;
    if (o_wr_clear !== 1'b1 || o_wr_index !== 8'h00) begin
      n_fail++;
      $display("FAIL sweep_restart: clr=%b idx=%h, required 1 00", o_wr_clear, o_wr_index);
    end
    repeat (255) @(negedge clk);
    n_checks++;
    if (o_wr_clear !== 1'b1 || o_wr_index !== 8'hff) begin
      n_fail++;
      $display("FAIL sweep_last: clr=%b idx=%h, required 1 ff", o_wr_clear, o_wr_index);
    end
    @(negedge clk);
    n_checks++;
    if (status() !== 6'b000110) begin
      n_fail++;
      $display("FAIL flush_dropped: status=%b idx=%h, required 000110 (B discarded)",
               status(), o_wr_index);
    end
`ifdef BHT_SCHED_STATS_EN
    n_checks++;
    if (o_commit_cnt !== 32'd15 || o_drop_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL stats: commit=%0d drop=%0d, required 15 1", o_commit_cnt, o_drop_cnt);
    end
`else
    n_checks++;
    if (o_commit_cnt !== 32'd0 || o_drop_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_tied: commit=%0d drop=%0d, required 0 0", o_commit_cnt, o_drop_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_sweep();
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++;
    if (o_wr_clear !== 1'b1 || o_wr_index !== 8'd100) begin
      n_fail++;
      $display("FAIL mid_sweep_idx: clr=%b idx=%0d, required 1 100", o_wr_clear, o_wr_index);
    end
    #2 rst = 1'b1;
    #1 check_reset_vals("async_reset");
    n_checks++;
    if (o_commit_cnt !== 32'd0 || o_drop_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset: commit=%0d drop=%0d, required 0 0", o_commit_cnt, o_drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (o_wr_clear !== 1'b1 || o_wr_index !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset_idx0: clr=%b idx=%h, required 1 00", o_wr_clear, o_wr_index);
    end
    @(negedge clk);
    n_checks++;
    if (o_wr_clear !== 1'b1 || o_wr_index !== 8'h01) begin
      n_fail++;
      $display("FAIL post_reset_idx1: clr=%b idx=%h, required 1 01", o_wr_clear, o_wr_index);
    end
  endtask

  initial begin
    test_reset();
    test_single_alloc();
    test_back_to_back();
    test_ready_hold();
    test_flush();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
